// File: rtl/key_debounce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ctrl_pkg
// Purpose  : Shared defaults, hold-FSM state encoding and counter sizing
//            helper for the multi-key debounce / event generator.
// Revision : 1.0 - initial release
// ============================================================================
package key_debounce_ctrl_pkg;

  // Default parameter values for the debounce block
  localparam int N_KEYS_DEF          = 4;
  localparam int DEB_SAMPLES_DEF     = 4;
  localparam int LONG_SAMPLES_DEF    = 64;
  localparam int REPEAT_SAMPLES_DEF  = 16;
  localparam int KEY_ACTIVE_HIGH_DEF = 1;

  // Per-key hold state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } hold_state_t;

  // Hold counter width. Normally LONG_SAMPLES dominates; the max() keeps the
  // repeat compare representable if a repeat interval longer than the
  // long-press threshold is ever configured.
  function automatic int hold_cnt_width(input int long_s, input int rep_s);
    int m;
    m = (long_s > rep_s) ? long_s : rep_s;
    return $clog2(m + 1);
  endfunction

endpackage : key_debounce_ctrl_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Purpose  : One pushbutton channel: sample shift register, debounced level,
//            press/release one-shots and the long-press / auto-repeat FSM.
//            All state advances only on the sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
  import key_debounce_ctrl_pkg::*;
#(
  parameter int DEB_SAMPLES    = DEB_SAMPLES_DEF,
  parameter int LONG_SAMPLES   = LONG_SAMPLES_DEF,
  parameter int REPEAT_SAMPLES = REPEAT_SAMPLES_DEF
) (
  input  logic clk_40M,
  input  logic rst,
  input  logic tick,
  input  logic s,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int CW = hold_cnt_width(LONG_SAMPLES, REPEAT_SAMPLES);
  localparam logic [CW-1:0] C_LONG   = CW'(LONG_SAMPLES);
  localparam logic [CW-1:0] C_REPEAT = CW'(REPEAT_SAMPLES);

  // Only the newest DEB_SAMPLES-1 samples need storing; the live sample
  // completes the qualification window.
  logic [DEB_SAMPLES-2:0] r_sh;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic                   r_repeat;
  hold_state_t            r_state;
  logic [CW-1:0]          r_cnt;

  logic [DEB_SAMPLES-1:0] w_window;
  logic                   w_rise;
  logic                   w_fall;
  logic [CW-1:0]          w_cnt_inc;
  logic [DEB_SAMPLES-2:0] w_sh_nxt;
  logic                   w_level_nxt;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_long_nxt;
  logic                   w_repeat_nxt;
  hold_state_t            w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;

  assign w_window  = {r_sh, s};
  assign w_rise    = tick & (&w_window)  & ~r_level;
  assign w_fall    = tick & (~|w_window) &  r_level;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state logic: sampling, debounced level, pulses and hold FSM
  always_comb begin
    w_sh_nxt      = r_sh;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;

    if (tick) begin
      w_sh_nxt = w_window[DEB_SAMPLES-2:0];
    end

    if (w_fall) begin
      // A release suppresses any threshold or repeat landing on this tick
      w_level_nxt   = 1'b0;
      w_release_nxt = 1'b1;
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
    end else if (tick) begin
      if (w_rise) begin
        w_level_nxt = 1'b1;
        w_press_nxt = 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = CW'(1);
          end
        end
        PRESSED: begin
          if (r_level) begin
            if (w_cnt_inc == C_LONG) begin
              w_long_nxt   = 1'b1;
              w_repeat_nxt = 1'b1;
              w_state_nxt  = LONG;
              w_cnt_nxt    = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        LONG: begin
          if (w_cnt_inc == C_REPEAT) begin
            w_repeat_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any press in progress
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_sh      <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
    end else begin
      r_sh      <= w_sh_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign key_repeat  = r_repeat;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ctrl
// Purpose  : Multi-key debounce and event generator. Synchronises the raw
//            keys and the slow clk_debounce strobe into clk_40M, derives a
//            one-cycle sample tick and runs one channel per key.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ctrl
  import key_debounce_ctrl_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEB_SAMPLES     = DEB_SAMPLES_DEF,
  parameter int LONG_SAMPLES    = LONG_SAMPLES_DEF,
  parameter int REPEAT_SAMPLES  = REPEAT_SAMPLES_DEF,
  parameter int KEY_ACTIVE_HIGH = KEY_ACTIVE_HIGH_DEF
) (
  input  logic              clk_40M,
  input  logic              rst,
  input  logic              clk_debounce,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  logic [N_KEYS-1:0] r_key_sync1;
  logic [N_KEYS-1:0] r_key_sync2;
  logic              r_deb_sync1;
  logic              r_deb_sync2;
  logic              r_deb_sync3;

  logic              w_tick;
  logic [N_KEYS-1:0] w_s;

  // Two-flop synchronisers for the raw keys
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_key_sync1 <= '0;
      r_key_sync2 <= '0;
    end else begin
      r_key_sync1 <= key_in;
      r_key_sync2 <= r_key_sync1;
    end
  end

  // clk_debounce is only a strobe: synchronise it and keep one extra stage
  // for rising-edge detection
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      r_deb_sync1 <= 1'b0;
      r_deb_sync2 <= 1'b0;
      r_deb_sync3 <= 1'b0;
    end else begin
      r_deb_sync1 <= clk_debounce;
      r_deb_sync2 <= r_deb_sync1;
      r_deb_sync3 <= r_deb_sync2;
    end
  end

  assign w_tick = r_deb_sync2 & ~r_deb_sync3;

  // Normalise polarity so the channels always see 1 = pressed
  assign w_s = (KEY_ACTIVE_HIGH != 0) ? r_key_sync2 : ~r_key_sync2;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_debounce_ch #(
      .DEB_SAMPLES    (DEB_SAMPLES),
      .LONG_SAMPLES   (LONG_SAMPLES),
      .REPEAT_SAMPLES (REPEAT_SAMPLES)
    ) u_ch (
      .clk_40M     (clk_40M),
      .rst         (rst),
      .tick        (w_tick),
      .s           (w_s[gi]),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi]),
      .key_long    (key_long[gi]),
      .key_repeat  (key_repeat[gi])
    );
  end : g_key

endmodule : key_debounce_ctrl
`default_nettype wire

// File: tb/tb_key_debounce_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_debounce_ctrl
// Purpose  : Directed self-checking bench for key_debounce_ctrl with
//            DEB=4, LONG=8, REPEAT=4 and a 16-cycle clk_debounce period.
//            Tick numbers below count clk_debounce rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_ctrl;

  localparam int NK = 4;

  logic          clk_40M = 1'b0;
  logic          rst;
  logic          clk_debounce;
  logic [NK-1:0] key_in_ah;
  logic [NK-1:0] key_in_al;
  logic [NK-1:0] key_level_ah, key_press_ah, key_release_ah, key_long_ah, key_repeat_ah;
  logic [NK-1:0] key_level_al, key_press_al, key_release_al, key_long_al, key_repeat_al;

  int passed = 0;
  int total  = 0;
  int phase;
  int tick_no;

  int press_cnt [NK];
  int press_tick[NK];
  int rel_cnt   [NK];
  int rel_tick  [NK];
  int long_cnt  [NK];
  int long_tick [NK];
  int rep_cnt   [NK];
  int rep_tick  [NK][8];
  int width_err;
  int coin_err;
  int al_press0;
  int al_other;
  logic [NK-1:0] p_press, p_rel, p_long, p_rep, p_level;

  int t0;

  key_debounce_ctrl #(
    .N_KEYS(NK), .DEB_SAMPLES(4), .LONG_SAMPLES(8), .REPEAT_SAMPLES(4), .KEY_ACTIVE_HIGH(1)
  ) dut_ah (
    .clk_40M(clk_40M), .rst(rst), .clk_debounce(clk_debounce), .key_in(key_in_ah),
    .key_level(key_level_ah), .key_press(key_press_ah), .key_release(key_release_ah),
    .key_long(key_long_ah), .key_repeat(key_repeat_ah)
  );

  key_debounce_ctrl #(
    .N_KEYS(NK), .DEB_SAMPLES(4), .LONG_SAMPLES(8), .REPEAT_SAMPLES(4), .KEY_ACTIVE_HIGH(0)
  ) dut_al (
    .clk_40M(clk_40M), .rst(rst), .clk_debounce(clk_debounce), .key_in(key_in_al),
    .key_level(key_level_al), .key_press(key_press_al), .key_release(key_release_al),
    .key_long(key_long_al), .key_repeat(key_repeat_al)
  );

  always #12 clk_40M = ~clk_40M;

  task automatic check(input string tag, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic clear_mon();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; press_tick[k] = -1;
      rel_cnt[k]   = 0; rel_tick[k]   = -1;
      long_cnt[k]  = 0; long_tick[k]  = -1;
      rep_cnt[k]   = 0;
      for (int j = 0; j < 8; j++) rep_tick[k][j] = -1;
    end
    width_err = 0;
    coin_err  = 0;
    al_press0 = 0;
    al_other  = 0;
  endtask

  // One clk_40M cycle: advance the strobe on the falling edge, then observe
  // the outputs 1 ns after the rising edge.
  task automatic cyc();
    @(negedge clk_40M);
    phase        = (phase + 1) % 16;
    clk_debounce = (phase < 8);
    if (phase == 0) tick_no++;
    @(posedge clk_40M);
    #1;
    for (int k = 0; k < NK; k++) begin
      if (key_press_ah[k]) begin
        press_cnt[k]++; press_tick[k] = tick_no;
        if (p_press[k]) width_err++;
        if (!key_level_ah[k] || p_level[k]) coin_err++;
      end
      if (key_release_ah[k]) begin
        rel_cnt[k]++; rel_tick[k] = tick_no;
        if (p_rel[k]) width_err++;
        if (key_level_ah[k] || !p_level[k]) coin_err++;
      end
      if (key_long_ah[k]) begin
        long_cnt[k]++; long_tick[k] = tick_no;
        if (p_long[k]) width_err++;
      end
      if (key_repeat_ah[k]) begin
        if (rep_cnt[k] < 8) rep_tick[k][rep_cnt[k]] = tick_no;
        rep_cnt[k]++;
        if (p_rep[k]) width_err++;
      end
    end
    p_press = key_press_ah;
    p_rel   = key_release_ah;
    p_long  = key_long_ah;
    p_rep   = key_repeat_ah;
    p_level = key_level_ah;
    if (key_press_al[0]) al_press0++;
    al_other += $countones(key_press_al[NK-1:1]) + $countones(key_release_al)
              + $countones(key_long_al) + $countones(key_repeat_al);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic ticks(input int n);
    run(16 * n);
  endtask

  initial begin
    rst          = 1'b1;
    clk_debounce = 1'b0;
    phase        = 8;
    tick_no      = 0;
    key_in_ah    = '0;
    key_in_al    = '1;
    p_press = '0; p_rel = '0; p_long = '0; p_rep = '0; p_level = '0;
    clear_mon();

    // Reset state
    run(3);
    check("reset_outputs_ah", int'({key_level_ah, key_press_ah, key_release_ah, key_long_ah, key_repeat_ah}), 0);
    check("reset_outputs_al", int'({key_level_al, key_press_al, key_release_al, key_long_al, key_repeat_al}), 0);
    rst = 1'b0;
    run(13);  // back to mid-low strobe phase

    // 1) clean press of key 0; active-low instance sees key 0 pressed too
    clear_mon();
    t0 = tick_no;
    key_in_ah[0] = 1'b1;
    key_in_al    = 4'b1110;
    ticks(3);
    check("k0_level_after_3", int'(key_level_ah[0]), 0);
    ticks(1);
    check("k0_level_after_4", int'(key_level_ah[0]), 1);
    check("k0_press_tick", press_tick[0], t0 + 4);
    check("al_level_after_4", int'(key_level_al), 4'b0001);
    ticks(2);
    check("k0_press_count", press_cnt[0], 1);
    check("k0_no_long", long_cnt[0], 0);
    check("al_press0_count", al_press0, 1);
    check("al_other_silent", al_other, 0);
    check("s1_pulse_width", width_err, 0);
    check("s1_pulse_coincide", coin_err, 0);
    t0 = tick_no;
    key_in_ah[0] = 1'b0;
    ticks(4);
    check("k0_release_tick", rel_tick[0], t0 + 4);
    check("k0_release_count", rel_cnt[0], 1);

    // 2) bounce on key 1: 5-cycle halves never give 4 equal 16-cycle samples
    clear_mon();
    for (int i = 0; i < 208; i++) begin
      cyc();
      if (i % 5 == 4) key_in_ah[1] = ~key_in_ah[1];
    end
    check("k1_no_press_bounce", press_cnt[1], 0);
    check("k1_level_bounce", int'(key_level_ah[1]), 0);
    t0 = tick_no;
    key_in_ah[1] = 1'b1;
    ticks(4);
    check("k1_press_count", press_cnt[1], 1);
    check("k1_press_window", int'(press_tick[1] > t0 && press_tick[1] <= t0 + 4), 1);
    check("k1_level_steady", int'(key_level_ah[1]), 1);
    check("s2_pulse_width", width_err, 0);
    key_in_ah[1] = 1'b0;
    ticks(5);

    // 3) long hold of key 2: press t0+4, long t0+11, repeats every 4 ticks
    clear_mon();
    t0 = tick_no;
    key_in_ah[2] = 1'b1;
    ticks(20);
    check("k2_press_tick", press_tick[2], t0 + 4);
    check("k2_long_count", long_cnt[2], 1);
    check("k2_long_tick", long_tick[2], t0 + 11);
    check("k2_rep0_tick", rep_tick[2][0], t0 + 11);
    check("k2_rep1_tick", rep_tick[2][1], t0 + 15);
    check("k2_rep2_tick", rep_tick[2][2], t0 + 19);
    key_in_ah[2] = 1'b0;
    ticks(4);
    // level is still high on tick t0+23, so one more repeat precedes release
    check("k2_rep3_tick", rep_tick[2][3], t0 + 23);
    check("k2_rep_count", rep_cnt[2], 4);
    check("k2_release_tick", rel_tick[2], t0 + 24);
    check("k2_release_count", rel_cnt[2], 1);
    check("s3_pulse_width", width_err, 0);

    // 4) release lands on the repeat boundary t0+15: release wins
    clear_mon();
    t0 = tick_no;
    key_in_ah[2] = 1'b1;
    ticks(11);
    key_in_ah[2] = 1'b0;
    ticks(4);
    check("k2b_long_tick", long_tick[2], t0 + 11);
    check("k2b_rep_count", rep_cnt[2], 1);
    check("k2b_release_tick", rel_tick[2], t0 + 15);
    check("k2b_level", int'(key_level_ah[2]), 0);

    // 5) reset while key 3 is in LONG
    clear_mon();
    t0 = tick_no;
    key_in_ah[3] = 1'b1;
    ticks(13);
    check("k3_long_count", long_cnt[3], 1);
    check("k3_level_pre_rst", int'(key_level_ah[3]), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs_ah", int'({key_level_ah, key_press_ah, key_release_ah, key_long_ah, key_repeat_ah}), 0);
    check("rst_mid_level_al", int'(key_level_al), 0);
    run(3);
    rst = 1'b0;
    clear_mon();
    t0 = tick_no;
    run(13);
    ticks(2);
    check("k3_no_press_3", press_cnt[3], 0);
    check("k3_level_3", int'(key_level_ah[3]), 0);
    ticks(1);
    check("k3_press_count", press_cnt[3], 1);
    check("k3_press_tick", press_tick[3], t0 + 4);
    check("al_level_post_rst", int'(key_level_al), 4'b0001);
    check("s5_pulse_width", width_err, 0);
    check("s5_pulse_coincide", coin_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_key_debounce_ctrl
`default_nettype wire
